// File: rtl/maze_pkg.sv
// Shared types and constants for the maze-solve command sequencer.
package maze_pkg;

  localparam int unsigned HDNG_BITS = 12;

  // Compass headings; positive delta turns left.
  localparam logic [HDNG_BITS-1:0] HDNG_N = 12'h000;
  localparam logic [HDNG_BITS-1:0] HDNG_W = 12'h400;
  localparam logic [HDNG_BITS-1:0] HDNG_S = 12'h800;
  localparam logic [HDNG_BITS-1:0] HDNG_E = 12'hC00;

  localparam logic [HDNG_BITS-1:0] QTR_TURN = 12'h400;

  typedef enum logic [2:0] {
    S_IDLE     = 3'd0,
    S_MV_ISSUE = 3'd1,
    S_MV_WAIT  = 3'd2,
    S_DECIDE   = 3'd3,
    S_HD_ISSUE = 3'd4,
    S_HD_WAIT  = 3'd5,
    S_DONE     = 3'd6
  } slv_state_t;

endpackage

// File: rtl/maze_turn_sel.sv
// Combinational heading-delta selector: wall-following affinity plus IR openings.
module maze_turn_sel #(
  parameter int unsigned          HDNG_W   = 12,
  parameter logic [HDNG_W-1:0]    QTR_TURN = 12'h400
) (
  input  logic              i_affn,
  input  logic              i_lft_opn,
  input  logic              i_rght_opn,
  output logic [HDNG_W-1:0] o_delta
);

  import maze_pkg::*;

  logic [HDNG_W-1:0] w_neg_qtr;
  logic [HDNG_W-1:0] w_uturn;

  assign w_neg_qtr = '0 - QTR_TURN;
  assign w_uturn   = QTR_TURN << 1;

  // Preferred side first, then the opposite side, otherwise turn around.
  always_comb begin
    o_delta = w_uturn;
    if (i_affn) begin
      if (i_lft_opn)       o_delta = QTR_TURN;
      else if (i_rght_opn) o_delta = w_neg_qtr;
    end else begin
      if (i_rght_opn)      o_delta = w_neg_qtr;
      else if (i_lft_opn)  o_delta = QTR_TURN;
    end
  end

endmodule

// File: rtl/maze_solve_ctrl.sv
// Wall-following maze-solve sequencer issuing move/heading commands to navigate.
module maze_solve_ctrl #(
  parameter int unsigned          HDNG_W   = 12,
  parameter logic [HDNG_W-1:0]    QTR_TURN = 12'h400
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cmd_md,
  input  logic              lft_affn,
  input  logic              mv_cmplt,
  input  logic              lft_opn,
  input  logic              rght_opn,
  input  logic              sol_cmplt,
  output logic              strt_mv,
  output logic              stp_lft,
  output logic              stp_rght,
  output logic              strt_hdng,
  output logic [HDNG_W-1:0] dsrd_hdng,
  output logic              slv_done,
  output logic [7:0]        mv_cnt
);

  import maze_pkg::*;

  slv_state_t        r_state;
  logic              r_affn;
  logic              r_strt_mv;
  logic              r_stp_lft;
  logic              r_stp_rght;
  logic              r_strt_hdng;
  logic [HDNG_W-1:0] r_dsrd_hdng;
  logic              r_slv_done;
  logic [7:0]        r_mv_cnt;
  logic [HDNG_W-1:0] w_delta;
  logic              w_abort;

  maze_turn_sel #(
    .HDNG_W   (HDNG_W),
    .QTR_TURN (QTR_TURN)
  ) u_turn_sel (
    .i_affn     (r_affn),
    .i_lft_opn  (lft_opn),
    .i_rght_opn (rght_opn),
    .o_delta    (w_delta)
  );

  assign w_abort = !cmd_md && (r_state != S_IDLE) && (r_state != S_DONE);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= S_IDLE;
      r_affn      <= 1'b0;
      r_strt_mv   <= 1'b0;
      r_stp_lft   <= 1'b0;
      r_stp_rght  <= 1'b0;
      r_strt_hdng <= 1'b0;
      r_dsrd_hdng <= '0;
      r_slv_done  <= 1'b0;
      r_mv_cnt    <= '0;
    end else begin
      r_strt_mv   <= 1'b0;
      r_strt_hdng <= 1'b0;
      // Abort wins over everything else, including a coincident mv_cmplt.
      if (w_abort) begin
        r_state    <= S_IDLE;
        r_stp_lft  <= 1'b0;
        r_stp_rght <= 1'b0;
      end else begin
        case (r_state)
          S_IDLE: begin
            r_stp_lft  <= 1'b0;
            r_stp_rght <= 1'b0;
            if (cmd_md) begin
              r_affn     <= lft_affn;
              r_state    <= S_MV_ISSUE;
              r_strt_mv  <= 1'b1;
              r_stp_lft  <= lft_affn;
              r_stp_rght <= !lft_affn;
            end
          end
          S_MV_ISSUE: r_state <= S_MV_WAIT;
          S_MV_WAIT: begin
            if (mv_cmplt) begin
              if (r_mv_cnt != 8'hFF) r_mv_cnt <= r_mv_cnt + 8'd1;
              r_stp_lft  <= 1'b0;
              r_stp_rght <= 1'b0;
              if (sol_cmplt) begin
                r_state    <= S_DONE;
                r_slv_done <= 1'b1;
              end else begin
                r_state <= S_DECIDE;
              end
            end
          end
          S_DECIDE: begin
            r_dsrd_hdng <= r_dsrd_hdng + w_delta;
            r_state     <= S_HD_ISSUE;
            r_strt_hdng <= 1'b1;
          end
          S_HD_ISSUE: r_state <= S_HD_WAIT;
          S_HD_WAIT: begin
            if (mv_cmplt) begin
              r_state    <= S_MV_ISSUE;
              r_strt_mv  <= 1'b1;
              r_stp_lft  <= r_affn;
              r_stp_rght <= !r_affn;
            end
          end
          S_DONE: begin
            if (!cmd_md) begin
              r_state    <= S_IDLE;
              r_slv_done <= 1'b0;
            end
          end
          default: begin
            r_state    <= S_IDLE;
            r_stp_lft  <= 1'b0;
            r_stp_rght <= 1'b0;
            r_slv_done <= 1'b0;
          end
        endcase
      end
    end
  end

  assign strt_mv   = r_strt_mv;
  assign stp_lft   = r_stp_lft;
  assign stp_rght  = r_stp_rght;
  assign strt_hdng = r_strt_hdng;
  assign dsrd_hdng = r_dsrd_hdng;
  assign slv_done  = r_slv_done;
  assign mv_cnt    = r_mv_cnt;

endmodule

// File: tb/tb_maze_solve_ctrl.sv
// Directed self-checking bench for maze_solve_ctrl.
module tb_maze_solve_ctrl;

  logic        clk = 1'b0;
  logic        rst, cmd_md, lft_affn, mv_cmplt, lft_opn, rght_opn, sol_cmplt;
  logic        strt_mv, stp_lft, stp_rght, strt_hdng, slv_done;
  logic [11:0] dsrd_hdng;
  logic [7:0]  mv_cnt;

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  maze_solve_ctrl #(
    .HDNG_W   (12),
    .QTR_TURN (12'h400)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .cmd_md    (cmd_md),
    .lft_affn  (lft_affn),
    .mv_cmplt  (mv_cmplt),
    .lft_opn   (lft_opn),
    .rght_opn  (rght_opn),
    .sol_cmplt (sol_cmplt),
    .strt_mv   (strt_mv),
    .stp_lft   (stp_lft),
    .stp_rght  (stp_rght),
    .strt_hdng (strt_hdng),
    .dsrd_hdng (dsrd_hdng),
    .slv_done  (slv_done),
    .mv_cnt    (mv_cnt)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1; cmd_md = 1'b1; lft_affn = 1'b1; mv_cmplt = 1'b0;
    lft_opn = 1'b0; rght_opn = 1'b0; sol_cmplt = 1'b0;
    tick(); tick();
    n_vec++; if (strt_mv !== 1'b0)    begin n_err++; $display("FAIL rst_strt_mv: got %0b exp 0", strt_mv); end
    n_vec++; if (strt_hdng !== 1'b0)  begin n_err++; $display("FAIL rst_strt_hdng: got %0b exp 0", strt_hdng); end
    n_vec++; if (stp_lft !== 1'b0)    begin n_err++; $display("FAIL rst_stp_lft: got %0b exp 0", stp_lft); end
    n_vec++; if (stp_rght !== 1'b0)   begin n_err++; $display("FAIL rst_stp_rght: got %0b exp 0", stp_rght); end
    n_vec++; if (dsrd_hdng !== 12'h000) begin n_err++; $display("FAIL rst_hdng: got %0h exp 000", dsrd_hdng); end
    n_vec++; if (slv_done !== 1'b0)   begin n_err++; $display("FAIL rst_slv_done: got %0b exp 0", slv_done); end
    n_vec++; if (mv_cnt !== 8'h00)    begin n_err++; $display("FAIL rst_mv_cnt: got %0h exp 00", mv_cnt); end
    rst = 1'b0;
    tick();  // MV_ISSUE
    n_vec++; if (strt_mv !== 1'b1)    begin n_err++; $display("FAIL start_strt_mv: got %0b exp 1", strt_mv); end
    n_vec++; if (stp_lft !== 1'b1 || stp_rght !== 1'b0) begin n_err++; $display("FAIL start_stp: got l=%0b r=%0b exp l=1 r=0", stp_lft, stp_rght); end
    tick();  // MV_WAIT
    n_vec++; if (strt_mv !== 1'b0)    begin n_err++; $display("FAIL start_pulse_len: got %0b exp 0", strt_mv); end
    n_vec++; if (stp_lft !== 1'b1)    begin n_err++; $display("FAIL wait_stp_lft: got %0b exp 1", stp_lft); end
  endtask

  task automatic test_left_turn();
    mv_cmplt = 1'b1; lft_opn = 1'b1; rght_opn = 1'b1;
    tick();  // DECIDE
    mv_cmplt = 1'b0;
    n_vec++; if (mv_cnt !== 8'd1)     begin n_err++; $display("FAIL lt_mv_cnt: got %0d exp 1", mv_cnt); end
    n_vec++; if (strt_hdng !== 1'b0)  begin n_err++; $display("FAIL lt_hdng_early: got %0b exp 0", strt_hdng); end
    tick();  // HD_ISSUE
    n_vec++; if (strt_hdng !== 1'b1)  begin n_err++; $display("FAIL lt_strt_hdng: got %0b exp 1", strt_hdng); end
    n_vec++; if (dsrd_hdng !== 12'h400) begin n_err++; $display("FAIL lt_hdng: got %0h exp 400", dsrd_hdng); end
    n_vec++; if (strt_mv !== 1'b0)    begin n_err++; $display("FAIL lt_no_mv: got %0b exp 0", strt_mv); end
    tick();  // HD_WAIT
    n_vec++; if (strt_hdng !== 1'b0)  begin n_err++; $display("FAIL lt_hdng_len: got %0b exp 0", strt_hdng); end
    mv_cmplt = 1'b1;
    tick();  // MV_ISSUE
    mv_cmplt = 1'b0;
    n_vec++; if (strt_mv !== 1'b1)    begin n_err++; $display("FAIL lt_next_mv: got %0b exp 1", strt_mv); end
    n_vec++; if (mv_cnt !== 8'd1)     begin n_err++; $display("FAIL lt_cnt_hold: got %0d exp 1", mv_cnt); end
    tick();  // MV_WAIT
  endtask

  task automatic test_dead_end_wrap();
    cmd_md = 1'b0;
    tick();  // abort to IDLE
    rst = 1'b1;
    tick();
    rst = 1'b0; cmd_md = 1'b1; lft_affn = 1'b0;
    tick();  // MV_ISSUE, right affinity
    n_vec++; if (stp_rght !== 1'b1 || stp_lft !== 1'b0) begin n_err++; $display("FAIL ra_stp: got l=%0b r=%0b exp l=0 r=1", stp_lft, stp_rght); end
    tick();  // MV_WAIT
    // both open, right preferred: 000 - 400 = C00
    mv_cmplt = 1'b1; lft_opn = 1'b1; rght_opn = 1'b1;
    tick(); mv_cmplt = 1'b0; tick();
    n_vec++; if (dsrd_hdng !== 12'hC00) begin n_err++; $display("FAIL ra_right_turn: got %0h exp C00", dsrd_hdng); end
    tick(); mv_cmplt = 1'b1; tick(); mv_cmplt = 1'b0; tick();
    // dead end: C00 + 800 wraps to 400
    mv_cmplt = 1'b1; lft_opn = 1'b0; rght_opn = 1'b0;
    tick(); mv_cmplt = 1'b0; tick();
    n_vec++; if (dsrd_hdng !== 12'h400) begin n_err++; $display("FAIL ra_dead_end: got %0h exp 400", dsrd_hdng); end
    tick(); mv_cmplt = 1'b1; tick(); mv_cmplt = 1'b0; tick();
    // only left open under right affinity: 400 + 400 = 800
    mv_cmplt = 1'b1; lft_opn = 1'b1; rght_opn = 1'b0;
    tick(); mv_cmplt = 1'b0; tick();
    n_vec++; if (dsrd_hdng !== 12'h800) begin n_err++; $display("FAIL ra_left_only: got %0h exp 800", dsrd_hdng); end
    n_vec++; if (mv_cnt !== 8'd3)     begin n_err++; $display("FAIL ra_mv_cnt: got %0d exp 3", mv_cnt); end
    tick(); mv_cmplt = 1'b1; tick(); mv_cmplt = 1'b0; tick();  // back in MV_WAIT
  endtask

  task automatic test_solve_done();
    mv_cmplt = 1'b1; sol_cmplt = 1'b1;
    tick();  // DONE
    mv_cmplt = 1'b0;
    n_vec++; if (slv_done !== 1'b1)   begin n_err++; $display("FAIL sd_done: got %0b exp 1", slv_done); end
    n_vec++; if (mv_cnt !== 8'd4)     begin n_err++; $display("FAIL sd_mv_cnt: got %0d exp 4", mv_cnt); end
    tick();
    n_vec++; if (strt_hdng !== 1'b0 || strt_mv !== 1'b0) begin n_err++; $display("FAIL sd_no_pulse: got h=%0b m=%0b exp 0 0", strt_hdng, strt_mv); end
    n_vec++; if (dsrd_hdng !== 12'h800) begin n_err++; $display("FAIL sd_hdng_hold: got %0h exp 800", dsrd_hdng); end
    mv_cmplt = 1'b1;
    tick();
    mv_cmplt = 1'b0;
    n_vec++; if (mv_cnt !== 8'd4 || slv_done !== 1'b1) begin n_err++; $display("FAIL sd_ignore_cmplt: got cnt=%0d done=%0b exp 4 1", mv_cnt, slv_done); end
    sol_cmplt = 1'b0; cmd_md = 1'b0;
    tick();  // IDLE
    n_vec++; if (slv_done !== 1'b0)   begin n_err++; $display("FAIL sd_clear: got %0b exp 0", slv_done); end
    tick();
    n_vec++; if (strt_mv !== 1'b0)    begin n_err++; $display("FAIL sd_idle_mv: got %0b exp 0", strt_mv); end
  endtask

  task automatic test_abort();
    logic seen;
    cmd_md = 1'b1; lft_affn = 1'b1;
    tick(); tick();  // MV_WAIT
    mv_cmplt = 1'b1; cmd_md = 1'b0;
    tick();  // IDLE
    mv_cmplt = 1'b0;
    n_vec++; if (mv_cnt !== 8'd4)     begin n_err++; $display("FAIL ab_mv_cnt: got %0d exp 4", mv_cnt); end
    n_vec++; if (stp_lft !== 1'b0)    begin n_err++; $display("FAIL ab_stp_lft: got %0b exp 0", stp_lft); end
    n_vec++; if (dsrd_hdng !== 12'h800) begin n_err++; $display("FAIL ab_hdng: got %0h exp 800", dsrd_hdng); end
    seen = 1'b0;
    for (int i = 0; i < 4; i++) begin
      tick();
      if (strt_mv || strt_hdng) seen = 1'b1;
    end
    n_vec++; if (seen !== 1'b0)       begin n_err++; $display("FAIL ab_no_pulse: got %0b exp 0", seen); end
  endtask

  task automatic test_saturation();
    rst = 1'b1;
    tick();
    rst = 1'b0; cmd_md = 1'b1; lft_affn = 1'b1; lft_opn = 1'b1; rght_opn = 1'b0;
    tick(); tick();  // MV_WAIT
    for (int i = 0; i < 260; i++) begin
      mv_cmplt = 1'b1;
      tick();  // DECIDE
      mv_cmplt = 1'b0;
      if (i == 253) begin
        n_vec++; if (mv_cnt !== 8'hFE) begin n_err++; $display("FAIL sat_fe: got %0h exp FE", mv_cnt); end
      end
      if (i == 254) begin
        n_vec++; if (mv_cnt !== 8'hFF) begin n_err++; $display("FAIL sat_ff: got %0h exp FF", mv_cnt); end
      end
      tick();  // HD_ISSUE
      if (strt_mv && strt_hdng) begin
        n_vec++; n_err++; $display("FAIL sat_overlap: got both pulses exp one");
      end
      tick();
      mv_cmplt = 1'b1;
      tick();
      mv_cmplt = 1'b0;
      tick();
    end
    n_vec++; if (mv_cnt !== 8'hFF)    begin n_err++; $display("FAIL sat_hold: got %0h exp FF", mv_cnt); end
    n_vec++; if (dsrd_hdng !== 12'h000) begin n_err++; $display("FAIL sat_hdng: got %0h exp 000", dsrd_hdng); end
  endtask

  initial begin
    test_reset();
    test_left_turn();
    test_dead_end_wrap();
    test_solve_done();
    test_abort();
    test_saturation();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
